// File: rtl/id_ex_pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg : shared definitions for the decode/execute boundary of the 5-stage
// core. Holds the datapath widths, the NOP encoding, the opcode values that the
// decoder and hazard unit agree on, and the packed control bundle carried by
// the ID/EX pipeline register.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int OPC_W  = 7;
    localparam int REG_W  = 3;
    localparam int DATA_W = 16;

    // An all-zero opcode is the architectural bubble.
    localparam logic [OPC_W-1:0] NOP_OPC = 7'b0000000;

    // Opcode values shared with the decoder and the hazard unit.
    localparam logic [OPC_W-1:0] OPC_LDM = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STM = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_ADD = 7'b0100000;
    localparam logic [OPC_W-1:0] OPC_SUB = 7'b0100001;
    localparam logic [OPC_W-1:0] OPC_BEQ = 7'b1100011;

    typedef struct packed {
        logic             valid;
        logic             load;
        logic             wb;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rsrc1;
        logic [REG_W-1:0] rsrc2;
        logic [REG_W-1:0] rdst;
    } id_ex_ctrl_t;

    // Control bundle of an empty EX slot (used for both flush and bubble).
    function automatic id_ex_ctrl_t ctrl_empty();
        id_ex_ctrl_t c;
        c.valid  = 1'b0;
        c.load   = 1'b0;
        c.wb     = 1'b0;
        c.opcode = NOP_OPC;
        c.rsrc1  = 3'd0;
        c.rsrc2  = 3'd0;
        c.rdst   = 3'd0;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_if : signal bundle between the decode stage / hazard unit and the
// ID/EX pipeline register.
//   slave  modport : pipeline register side (consumes id_* and stall/flush,
//                    produces ex_*, hold_fd, stall_err, perf_bubbles)
//   master modport : decode/hazard side (the mirror image)
// -----------------------------------------------------------------------------
interface id_ex_pipe_if;
    import pipe_pkg::*;

    logic              stallD;
    logic              stallE;
    logic              flushE;
    logic              id_valid;
    logic [OPC_W-1:0]  id_opcode;
    logic [REG_W-1:0]  id_rsrc1;
    logic [REG_W-1:0]  id_rsrc2;
    logic [REG_W-1:0]  id_rdst;
    logic              id_load;
    logic              id_wb;
    logic [DATA_W-1:0] id_op1;
    logic [DATA_W-1:0] id_op2;

    logic              ex_valid;
    logic              ex_load;
    logic              ex_wb;
    logic [OPC_W-1:0]  ex_opcode;
    logic [REG_W-1:0]  ex_rsrc1;
    logic [REG_W-1:0]  ex_rsrc2;
    logic [REG_W-1:0]  ex_rdst;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic              hold_fd;
    logic              stall_err;
    logic [15:0]       perf_bubbles;

    modport slave (
        input  stallD, stallE, flushE,
        input  id_valid, id_opcode, id_rsrc1, id_rsrc2, id_rdst,
        input  id_load, id_wb, id_op1, id_op2,
        output ex_valid, ex_load, ex_wb, ex_opcode,
        output ex_rsrc1, ex_rsrc2, ex_rdst, ex_op1, ex_op2,
        output hold_fd, stall_err, perf_bubbles
    );

    modport master (
        output stallD, stallE, flushE,
        output id_valid, id_opcode, id_rsrc1, id_rsrc2, id_rdst,
        output id_load, id_wb, id_op1, id_op2,
        input  ex_valid, ex_load, ex_wb, ex_opcode,
        input  ex_rsrc1, ex_rsrc2, ex_rdst, ex_op1, ex_op2,
        input  hold_fd, stall_err, perf_bubbles
    );

endinterface

// File: rtl/id_ex_pipe_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog : counts consecutive load-use stall cycles and raises a sticky
// error once a run reaches MAX_STALL. A memory stall freezes the run (the
// decode stall is not making progress, but neither is it the cause).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   stall_d_i     load-use stall from the hazard unit
//   stall_e_i     memory-stage stall
//   stall_err_o   sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module stall_watchdog #(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_d_i,
    input  logic stall_e_i,
    output logic stall_err_o
);

    logic [2:0] run_cnt_q, run_cnt_d;
    logic       err_q, err_d;

    // Next-state: run counter (saturating at 7) and sticky error.
    always_comb begin
        run_cnt_d = run_cnt_q;
        err_d     = err_q;
        if (!stall_d_i) begin
            run_cnt_d = 3'd0;
        end else if (stall_e_i) begin
            run_cnt_d = run_cnt_q;
        end else begin
            if (run_cnt_q != 3'd7) begin
                run_cnt_d = run_cnt_q + 3'd1;
            end else begin
                run_cnt_d = run_cnt_q;
            end
            // Flag on the edge that brings the run up to MAX_STALL.
            if ((32'(run_cnt_q) + 32'd1) == MAX_STALL) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // State register for run counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

    assign stall_err_o = err_q;

endmodule

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe : decode-to-execute pipeline register of the 5-stage core.
// Captures decoded fields every cycle and feeds ex_valid/ex_load/ex_rdst back
// to the hazard unit. Edge priority for the EX register:
//   flushE (empty slot) > stallE (hold) > stallD (bubble) > capture.
// hold_fd = stallE | stallD freezes PC and IF/ID combinationally.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         id_ex_pipe_if.slave: stall/flush and id_* in; ex_*, hold_fd,
//               stall_err, perf_bubbles out
// Build option:
//   ID_EX_PERF_EN  when defined, perf_bubbles counts inserted bubbles
//                  (saturating); otherwise perf_bubbles is tied to zero.
// -----------------------------------------------------------------------------
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_pipe_if.slave  bus
);

    id_ex_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              stall_err_s;

    // Next-state for the EX register following the flush/hold/bubble/capture order.
    always_comb begin
        ctrl_d = ctrl_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        if (bus.flushE) begin
            ctrl_d = ctrl_empty();
            op1_d  = 16'h0000;
            op2_d  = 16'h0000;
        end else if (bus.stallE) begin
            ctrl_d = ctrl_q;
            op1_d  = op1_q;
            op2_d  = op2_q;
        end else if (bus.stallD) begin
            ctrl_d = ctrl_empty();
            op1_d  = 16'h0000;
            op2_d  = 16'h0000;
        end else begin
            ctrl_d.valid  = bus.id_valid;
            // An empty decode slot must never look like a load or a writer.
            ctrl_d.load   = bus.id_valid & bus.id_load;
            ctrl_d.wb     = bus.id_valid & bus.id_wb;
            ctrl_d.opcode = bus.id_opcode;
            ctrl_d.rsrc1  = bus.id_rsrc1;
            ctrl_d.rsrc2  = bus.id_rsrc2;
            ctrl_d.rdst   = bus.id_rdst;
            op1_d         = bus.id_op1;
            op2_d         = bus.id_op2;
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= ctrl_empty();
            op1_q  <= 16'h0000;
            op2_q  <= 16'h0000;
        end else begin
            ctrl_q <= ctrl_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
        end
    end

    assign bus.ex_valid  = ctrl_q.valid;
    assign bus.ex_load   = ctrl_q.load;
    assign bus.ex_wb     = ctrl_q.wb;
    assign bus.ex_opcode = ctrl_q.opcode;
    assign bus.ex_rsrc1  = ctrl_q.rsrc1;
    assign bus.ex_rsrc2  = ctrl_q.rsrc2;
    assign bus.ex_rdst   = ctrl_q.rdst;
    assign bus.ex_op1    = op1_q;
    assign bus.ex_op2    = op2_q;

    // flushE deliberately does not mask the front-end hold.
    assign bus.hold_fd = bus.stallE | bus.stallD;

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_d_i   (bus.stallD),
        .stall_e_i   (bus.stallE),
        .stall_err_o (stall_err_s)
    );

    assign bus.stall_err = stall_err_s;

`ifdef ID_EX_PERF_EN
    logic [15:0] bub_cnt_q, bub_cnt_d;
    logic        bubble_s;

    // A bubble is only inserted when neither flush nor memory stall overrides it.
    assign bubble_s = bus.stallD & ~bus.stallE & ~bus.flushE;

    // Next-state for the saturating bubble counter.
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        if (bubble_s && (bub_cnt_q != 16'hFFFF)) begin
            bub_cnt_d = bub_cnt_q + 16'd1;
        end else begin
            bub_cnt_d = bub_cnt_q;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_cnt_q <= 16'h0000;
        end else begin
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign bus.perf_bubbles = bub_cnt_q;
`else
    assign bus.perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe : table-driven bench for id_ex_pipe plus hand-written sequences
// for reset-in-flight, isolated bubble counting and the stall watchdog.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;
    import pipe_pkg::*;

`ifdef ID_EX_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    id_ex_pipe_if bus();

    id_ex_pipe #(.MAX_STALL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd, se, fe, v;
        logic [6:0]  opc;
        logic [2:0]  rs1, rs2, rd;
        logic        ld, wb;
        logic [15:0] op1, op2;
        logic        e_hold, e_v, e_ld, e_wb;
        logic [6:0]  e_opc;
        logic [2:0]  e_rs1, e_rs2, e_rd;
        logic [15:0] e_op1, e_op2;
        int          e_bub;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.stallD    = 1'b0;
        bus.stallE    = 1'b0;
        bus.flushE    = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_opcode = 7'd0;
        bus.id_rsrc1  = 3'd0;
        bus.id_rsrc2  = 3'd0;
        bus.id_rdst   = 3'd0;
        bus.id_load   = 1'b0;
        bus.id_wb     = 1'b0;
        bus.id_op1    = 16'h0000;
        bus.id_op2    = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int i, input vec_t t);
        bus.stallD    = t.sd;
        bus.stallE    = t.se;
        bus.flushE    = t.fe;
        bus.id_valid  = t.v;
        bus.id_opcode = t.opc;
        bus.id_rsrc1  = t.rs1;
        bus.id_rsrc2  = t.rs2;
        bus.id_rdst   = t.rd;
        bus.id_load   = t.ld;
        bus.id_wb     = t.wb;
        bus.id_op1    = t.op1;
        bus.id_op2    = t.op2;
        #1;
        check($sformatf("v%0d hold_fd", i), 32'(bus.hold_fd), 32'(t.e_hold));
        step();
        check($sformatf("v%0d ex_valid", i),  32'(bus.ex_valid),  32'(t.e_v));
        check($sformatf("v%0d ex_load", i),   32'(bus.ex_load),   32'(t.e_ld));
        check($sformatf("v%0d ex_wb", i),     32'(bus.ex_wb),     32'(t.e_wb));
        check($sformatf("v%0d ex_opcode", i), 32'(bus.ex_opcode), 32'(t.e_opc));
        check($sformatf("v%0d ex_rsrc1", i),  32'(bus.ex_rsrc1),  32'(t.e_rs1));
        check($sformatf("v%0d ex_rsrc2", i),  32'(bus.ex_rsrc2),  32'(t.e_rs2));
        check($sformatf("v%0d ex_rdst", i),   32'(bus.ex_rdst),   32'(t.e_rd));
        check($sformatf("v%0d ex_op1", i),    32'(bus.ex_op1),    32'(t.e_op1));
        check($sformatf("v%0d ex_op2", i),    32'(bus.ex_op2),    32'(t.e_op2));
        check($sformatf("v%0d perf_bubbles", i), 32'(bus.perf_bubbles),
              PERF_ON ? 32'(t.e_bub) : 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            sd    se    fe    v     opc      rs1   rs2   rd    ld    wb    op1        op2
        //            hold  e_v   e_ld  e_wb  e_opc    e_rs1 e_rs2 e_rd  e_op1      e_op2      bub
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_LDM, 3'd2, 3'd0, 3'd3, 1'b1, 1'b1, 16'h1000, 16'h0004,
                     1'b0, 1'b1, 1'b1, 1'b1, OPC_LDM, 3'd2, 3'd0, 3'd3, 16'h1000, 16'h0004, 0};
        // load-use: ADD r1,r3 held in decode, bubble goes to EX
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd3, 3'd4, 1'b0, 1'b1, 16'h0011, 16'h0022,
                     1'b1, 1'b0, 1'b0, 1'b0, NOP_OPC, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd3, 3'd4, 1'b0, 1'b1, 16'h0011, 16'h0022,
                     1'b0, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd3, 3'd4, 16'h0011, 16'h0022, 1};
        // invalid slot: load/wb forced low, fields still captured
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, OPC_SUB, 3'd5, 3'd6, 3'd7, 1'b1, 1'b1, 16'hAAAA, 16'h5555,
                     1'b0, 1'b0, 1'b0, 1'b0, OPC_SUB, 3'd5, 3'd6, 3'd7, 16'hAAAA, 16'h5555, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_SUB, 3'd5, 3'd6, 3'd7, 1'b0, 1'b1, 16'h1234, 16'hBEEF,
                     1'b0, 1'b1, 1'b0, 1'b1, OPC_SUB, 3'd5, 3'd6, 3'd7, 16'h1234, 16'hBEEF, 1};
        // memory stall for three edges; middle one also has stallD (no bubble)
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd1, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h0000,
                     1'b1, 1'b1, 1'b0, 1'b1, OPC_SUB, 3'd5, 3'd6, 3'd7, 16'h1234, 16'hBEEF, 1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd1, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h0000,
                     1'b1, 1'b1, 1'b0, 1'b1, OPC_SUB, 3'd5, 3'd6, 3'd7, 16'h1234, 16'hBEEF, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd1, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h0000,
                     1'b1, 1'b1, 1'b0, 1'b1, OPC_SUB, 3'd5, 3'd6, 3'd7, 16'h1234, 16'hBEEF, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 16'h0101, 16'h0202,
                     1'b0, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd2, 3'd3, 16'h0101, 16'h0202, 1};
        // flush beats memory stall and load-use stall; hold_fd still high
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, OPC_ADD, 3'd2, 3'd2, 3'd2, 1'b0, 1'b1, 16'h0303, 16'h0404,
                     1'b1, 1'b0, 1'b0, 1'b0, NOP_OPC, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, OPC_ADD, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 16'h0303, 16'h0404,
                     1'b0, 1'b0, 1'b0, 1'b0, NOP_OPC, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_LDM, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 16'h0040, 16'h0008,
                     1'b0, 1'b1, 1'b1, 1'b1, OPC_LDM, 3'd0, 3'd0, 3'd2, 16'h0040, 16'h0008, 1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd3, 3'd4, 1'b0, 1'b1, 16'h1234, 16'h0000,
                     1'b0, 1'b1, 1'b0, 1'b1, OPC_ADD, 3'd1, 3'd3, 3'd4, 16'h1234, 16'h0000, 1};

        // Reset state
        rst_n = 1'b0;
        drive_idle();
        #2;
        check("rst ex_valid",     32'(bus.ex_valid),     32'd0);
        check("rst ex_opcode",    32'(bus.ex_opcode),    32'(NOP_OPC));
        check("rst ex_op1",       32'(bus.ex_op1),       32'd0);
        check("rst stall_err",    32'(bus.stall_err),    32'd0);
        check("rst perf_bubbles", 32'(bus.perf_bubbles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply(i, vecs[i]);
        end
        check("table stall_err", 32'(bus.stall_err), 32'd0);

        // Reset asserted mid-cycle while EX holds a live instruction
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst ex_valid",  32'(bus.ex_valid),     32'd0);
        check("midrst ex_op1",    32'(bus.ex_op1),       32'd0);
        check("midrst ex_opcode", 32'(bus.ex_opcode),    32'd0);
        check("midrst ex_wb",     32'(bus.ex_wb),        32'd0);
        check("midrst ex_rsrc2",  32'(bus.ex_rsrc2),     32'd0);
        check("midrst perf",      32'(bus.perf_bubbles), 32'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Five isolated load-use stalls
        for (int k = 0; k < 5; k++) begin
            bus.stallD = 1'b1;
            step();
            bus.stallD = 1'b0;
            step();
        end
        check("perf five bubbles", 32'(bus.perf_bubbles), PERF_ON ? 32'd5 : 32'd0);
        check("perf no watchdog",  32'(bus.stall_err),    32'd0);

        // Three-cycle run stays below the watchdog limit
        bus.stallD = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("wd run3 at end", 32'(bus.stall_err), 32'd0);
        bus.stallD = 1'b0;
        step();
        step();
        check("wd run3 after", 32'(bus.stall_err), 32'd0);

        // Four-cycle run trips the watchdog on the fourth edge, and it sticks
        bus.stallD = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("wd run4 edge3", 32'(bus.stall_err), 32'd0);
        step();
        check("wd run4 edge4", 32'(bus.stall_err), 32'd1);
        bus.stallD = 1'b0;
        step();
        step();
        check("wd sticky", 32'(bus.stall_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register of the 5-stage core.
- Captures decoded fields each cycle and drives ex_valid, ex_load and ex_rdst back to the hazard unit.
- Consumes stallD from the hazard unit. On a stall it inserts a bubble into EX and holds PC and IF/ID.
- Also applies EX flush (branch/interrupt), downstream memory stall, and a consecutive-stall watchdog.

Parameters:
- DATA_W, 16, operand width
- REG_W, 3, register index width
- OPC_W, 7, opcode width
- MAX_STALL, 4, consecutive stallD cycles before stall_err sets

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stallD  in  1  load-use stall from hazard unit
- stallE  in  1  memory-stage stall; freeze EX register
- flushE  in  1  kill the instruction entering EX
- id_valid  in  1  decode slot holds an instruction
- id_opcode  in  OPC_W  decoded opcode
- id_rsrc1, id_rsrc2  in  REG_W  source registers
- id_rdst  in  REG_W  destination register
- id_load  in  1  instruction is a load
- id_wb  in  1  instruction writes back
- id_op1, id_op2  in  DATA_W  operand values
- ex_valid, ex_load, ex_wb  out  1  registered controls
- ex_opcode  out  OPC_W  registered opcode
- ex_rsrc1, ex_rsrc2, ex_rdst  out  REG_W  registered indices
- ex_op1, ex_op2  out  DATA_W  registered operands
- hold_fd  out  1  hold PC and IF/ID (combinational)
- stall_err  out  1  sticky watchdog flag
- perf_bubbles  out  16  bubble count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): every registered output = 0. ex_opcode = NOP_OPC (all zeros).
- Per-edge priority for the EX register, highest first:
  1. flushE: ex_valid, ex_load, ex_wb = 0; other fields = 0. Flush wins over stallE.
  2. stallE: hold all ex_* unchanged.
  3. stallD: bubble. Controls = 0, ex_opcode = NOP_OPC, indices/operands = 0.
  4. Otherwise capture: ex_* <= id_*, ex_valid <= id_valid. If id_valid = 0, ex_load and ex_wb are forced to 0.
- hold_fd = stallE | stallD. It is combinational, with no added latency, and flushE does not mask it.
- Latency: one cycle from id_* to ex_*.
- A bubble clears ex_load. With steady inputs, stallD therefore lasts exactly one cycle per load-use pair.
- stallD together with stallE: hold takes priority, and no bubble is counted.
- Watchdog:
  - A 3-bit run counter increments each cycle stallD = 1 and stallE = 0. It saturates at 7.
  - It clears on any cycle with stallD = 0.
  - When the counter would reach MAX_STALL, stall_err sets. It stays set until reset.
  - The run counter holds during stallE.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: perf_bubbles increments by 1 on every edge where a bubble is inserted (priority case 3). It saturates at 16'hFFFF and resets to 0.
- Not defined: perf_bubbles is tied to 16'h0000 and no counter logic is built. The port is always present.

Decomposition:
- Package pipe_pkg holds:
  - OPC_W, REG_W, DATA_W
  - NOP_OPC
  - opcode localparams shared with the hazard unit and decoder
  - a packed struct id_ex_ctrl_t {valid, load, wb, opcode, rsrc1, rsrc2, rdst}
- One sub-module, stall_watchdog: run counter and sticky stall_err, parameterised by MAX_STALL.

Test Plan:
- Reset mid-stream: rst_n low while ex_valid = 1 and ex_op1 = 16'h1234 -> all outputs 0 immediately, before the next clock edge.
- Load-use pair: LDM to r3, then ADD r1,r3. stallD = 1 for one cycle -> hold_fd = 1 that cycle; next edge ex_valid = 0 and ex_opcode = NOP_OPC; following edge ex_opcode = 7'b0100000 and ex_rsrc2 = 3.
- Flush vs stall: flushE = 1, stallE = 1 and stallD = 1 in the same cycle -> ex_valid = 0, perf_bubbles unchanged, hold_fd = 1.
- Memory stall: stallE = 1 for 3 cycles with ex_op2 = 16'hBEEF -> ex_* constant for 3 edges; capture resumes on the 4th.
- Watchdog: stallD forced high with stallE = 0 for 4 cycles (MAX_STALL = 4) -> stall_err = 1 after the 4th edge and stays 1 after stallD drops. With 3 cycles -> stall_err = 0.
- Perf (ID_EX_PERF_EN defined): 5 isolated load-use stalls -> perf_bubbles = 5. Macro undefined -> perf_bubbles = 0.
